mem_rr_ctrl: RTL and testbench

- Round-robin controller that shares one my_mem_if-style memory port between two requesters (port 0, port 1).
- Sequences each accepted request into a single mem_write pulse, or a mem_read pulse followed by a fixed read-latency wait.
- Never asserts mem_read and mem_write together.
- Checks even parity on returned read data (mem_data_out[8] == ^mem_data_out[7:0]) and counts parity errors.

---
 rtl/mem_rr_ctrl.sv | 114 +++++++++++
 tb/tb_mem_rr_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rr_ctrl.sv
// mem_rr_ctrl: round-robin sharing of one memory port between two requesters, with read parity checking
module mem_rr_ctrl #(
    parameter int RD_LAT = 1,
    parameter int PERR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [15:0]       addr0,
    input  logic [15:0]       addr1,
    input  logic [7:0]        wdata0,
    input  logic [7:0]        wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [7:0]        rdata,
    output logic              perr,
    output logic [PERR_W-1:0] perr_cnt,
    output logic              mem_read,
    output logic              mem_write,
    output logic [15:0]       mem_address,
    output logic [7:0]        mem_data_in,
    input  logic [8:0]        mem_data_out
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
    state_t     state;
    logic       rr;
    logic       sel;
    logic       is_wr;
    logic       pick;
    logic       pick_we;
    logic       par_err;
    logic [3:0] cnt;

    // Choose the requester (rr names the port favoured on contention) and check even parity
    always_comb begin
        pick    = (req0 && req1) ? rr : req1;
        pick_we = pick ? we1 : we0;
        par_err = mem_data_out[8] != ^mem_data_out[7:0];
    end

    // Access sequencer: grant, one strobe cycle, optional read wait, one done cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            rr          <= 1'b0;
            sel         <= 1'b0;
            is_wr       <= 1'b0;
            cnt         <= 4'd0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            perr        <= 1'b0;
            mem_address <= 16'd0;
            mem_data_in <= 8'd0;
            rdata       <= 8'd0;
            perr_cnt    <= '0;
        end else begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            case (state)
                IDLE: if (req0 || req1) begin
                    sel         <= pick;
                    rr          <= ~pick;
                    gnt0        <= ~pick;
                    gnt1        <= pick;
                    is_wr       <= pick_we;
                    mem_address <= pick ? addr1 : addr0;
                    mem_data_in <= pick ? wdata1 : wdata0;
                    mem_write   <= pick_we;
                    mem_read    <= ~pick_we;
                    state       <= ACCESS;
                end
                ACCESS: if (is_wr) begin
                    done0 <= ~sel;
                    done1 <= sel;
                    perr  <= 1'b0;
                    state <= DONE;
                end else begin
                    cnt   <= 4'(RD_LAT);
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        rdata    <= mem_data_out[7:0];
                        perr     <= par_err;
                        perr_cnt <= (par_err && perr_cnt != '1) ? perr_cnt + PERR_W'(1) : perr_cnt;
                        done0    <= ~sel;
                        done1    <= sel;
                        state    <= DONE;
                    end
                end
                default: begin
                    perr  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    a_strobe_excl: assert property (@(posedge clk) disable iff (!reset_n) !(mem_read && mem_write));
endmodule

// File: tb/tb_mem_rr_ctrl.sv
// tb_mem_rr_ctrl: directed and randomized checks of mem_rr_ctrl against a transaction-level model
module tb_mem_rr_ctrl;
    localparam int RD_LAT = 3;
    localparam int N      = 10000;
    localparam int M      = N + 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [15:0] addr0 = '0, addr1 = '0;
    logic [7:0]  wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, done0, done1, perr, mem_read, mem_write;
    logic [7:0]  rdata, mem_data_in, perr_cnt;
    logic [15:0] mem_address;
    logic [8:0]  mem_data_out = '0;

    int n_cmp = 0;
    int n_err = 0;

    // Expected per-cycle activity: {gnt0, gnt1, done0, done1, mem_read, mem_write}
    logic [5:0]  e_ctl  [M];
    logic [15:0] e_addr [M];
    logic [7:0]  e_wd   [M];
    logic        e_wr   [M];
    logic [8:0]  drv    [M];
    logic        rq [2];
    logic        rw [2];
    logic [15:0] ra [2];
    logic [7:0]  rd [2];
    int          gap [2];

    always #5 clk = ~clk;

    mem_rr_ctrl #(.RD_LAT(RD_LAT), .PERR_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .perr(perr), .perr_cnt(perr_cnt),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    function automatic logic [5:0] ctl();
        return {gnt0, gnt1, done0, done1, mem_read, mem_write};
    endfunction

    function automatic logic pulse(input int s);
        return (s == 0) ? gnt0 : (s == 1) ? gnt1 : (s == 2) ? done0 : done1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input int p, input logic w, input logic [15:0] a, input logic [7:0] d);
        if (p == 0) begin
            req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    // Counts negedges until the selected pulse is seen; 50 means it never came
    task automatic wait_pulse(input int s, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pulse(s) && n < 50);
    endtask

    initial begin
        int n, n2, nxt, last, mcnt, p, g, d;
        int cg[2], cd[2], mg[2];
        int gport[$], gcyc[$];
        logic err;

        // Reset state
        @(negedge clk);
        chk("rst_ctl", ctl(), 6'b0);
        chk("rst_addr", mem_address, 16'h0);
        chk("rst_wdata", mem_data_in, 8'h0);
        chk("rst_rdata", rdata, 8'h0);
        chk("rst_perr", perr, 1'b0);
        chk("rst_perr_cnt", perr_cnt, 8'h0);
        reset_n = 1'b1;

        // Single write on port 0
        start(0, 1'b1, 16'h1234, 8'hA5);
        wait_pulse(0, n);
        chk("t1_gnt_lat", n, 1);
        chk("t1_gnt_ctl", ctl(), 6'b100001);
        chk("t1_addr", mem_address, 16'h1234);
        chk("t1_wdata", mem_data_in, 8'hA5);
        req0 = 1'b0;
        wait_pulse(2, n);
        chk("t1_done_lat", n, 1);
        chk("t1_done_ctl", ctl(), 6'b001000);
        chk("t1_perr", perr, 1'b0);
        @(negedge clk);
        chk("t1_idle_ctl", ctl(), 6'b0);

        // Single read on port 1 with good parity
        mem_data_out = 9'h101;
        start(1, 1'b0, 16'h00FF, 8'h00);
        wait_pulse(1, n);
        chk("t2_gnt_ctl", ctl(), 6'b010010);
        chk("t2_addr", mem_address, 16'h00FF);
        req1 = 1'b0;
        @(negedge clk);
        chk("t2_read_drop", ctl(), 6'b0);
        wait_pulse(3, n);
        chk("t2_done_lat", n + 1, RD_LAT + 1);
        chk("t2_done_ctl", ctl(), 6'b000100);
        chk("t2_rdata", rdata, 8'h01);
        chk("t2_perr", perr, 1'b0);
        @(negedge clk);

        // Contention from reset: both ports write continuously
        reset_n = 1'b0;
        start(0, 1'b1, 16'h0A0A, 8'h11);
        start(1, 1'b1, 16'h0B0B, 8'h22);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            chk("t3_two_gnt", gnt0 & gnt1, 1'b0);
            if (gnt0 || gnt1) begin
                gport.push_back(int'(gnt1));
                gcyc.push_back(c);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk("t3_gnt_count", gport.size(), 6);
        for (int i = 0; i < 4; i++) begin
            chk("t3_order", gport[i], i % 2);
            chk("t3_spacing", gcyc[i] - gcyc[0], 3 * i);
        end
        repeat (3) @(negedge clk);

        // Parity errors, saturating counter
        mem_data_out = 9'h103;
        for (int i = 0; i < 300; i++) begin
            start(0, 1'b0, 16'h0040 + 16'(i), 8'h00);
            wait_pulse(0, n);
            req0 = 1'b0;
            wait_pulse(2, n2);
            if (i == 0) begin
                chk("t4_done_lat", n2, RD_LAT + 1);
                chk("t4_perr", perr, 1'b1);
                chk("t4_rdata", rdata, 8'h03);
                chk("t4_perr_cnt1", perr_cnt, 8'd1);
            end
            if (i == 254 || i == 299) chk("t4_perr_cnt_sat", perr_cnt, 8'hFF);
            @(negedge clk);
        end

        // Reset in the middle of a read wait
        start(1, 1'b0, 16'h0ABC, 8'h00);
        wait_pulse(1, n);
        req1 = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_async_ctl", ctl(), 6'b0);
        chk("t5_async_perr_cnt", perr_cnt, 8'h0);
        chk("t5_async_addr", mem_address, 16'h0);
        @(negedge clk);
        chk("t5_no_done", ctl(), 6'b0);
        start(1, 1'b0, 16'h0DEF, 8'h00);
        reset_n = 1'b1;
        wait_pulse(1, n);
        chk("t5_gnt_lat", n, 1);
        chk("t5_addr", mem_address, 16'h0DEF);
        req1 = 1'b0;
        wait_pulse(3, n);
        chk("t5_done_lat", n, RD_LAT + 1);
        chk("t5_perr_cnt", perr_cnt, 8'd1);
        @(negedge clk);

        // Random traffic against a transaction-level schedule
        foreach (e_ctl[i]) begin
            e_ctl[i] = '0;
            e_wr[i]  = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            rq[i] = 1'b0; rw[i] = 1'b0; ra[i] = '0; rd[i] = '0;
            gap[i] = 0; cg[i] = 0; cd[i] = 0; mg[i] = 0;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        nxt  = 0;
        last = 1;
        mcnt = 0;
        for (int t = 0; t < N + 40; t++) begin
            if (t > 0) @(negedge clk);
            chk("rnd_ctl", ctl(), e_ctl[t]);
            chk("rnd_excl", mem_read & mem_write, 1'b0);
            cg[0] += int'(gnt0); cg[1] += int'(gnt1);
            cd[0] += int'(done0); cd[1] += int'(done1);
            if (e_ctl[t][5] || e_ctl[t][4]) begin
                chk("rnd_addr", mem_address, e_addr[t]);
                if (e_wr[t]) chk("rnd_wdata", mem_data_in, e_wd[t]);
            end
            if (e_ctl[t][3] || e_ctl[t][2]) begin
                if (e_wr[t]) chk("rnd_wr_perr", perr, 1'b0);
                else begin
                    err = drv[t-1][8] != ^drv[t-1][7:0];
                    chk("rnd_rdata", rdata, drv[t-1][7:0]);
                    chk("rnd_perr", perr, err);
                    if (err && mcnt < 255) mcnt++;
                end
            end
            chk("rnd_perr_cnt", perr_cnt, mcnt);
            for (int q = 0; q < 2; q++) begin
                if (e_ctl[t][5-q]) begin
                    rq[q]  = 1'b0;
                    gap[q] = $urandom_range(0, 4);
                end else if (!rq[q] && t < N) begin
                    if (gap[q] == 0) begin
                        rq[q] = 1'b1;
                        rw[q] = 1'($urandom_range(0, 1));
                        ra[q] = 16'($urandom);
                        rd[q] = 8'($urandom);
                    end else gap[q]--;
                end
            end
            req0 = rq[0]; we0 = rw[0]; addr0 = ra[0]; wdata0 = rd[0];
            req1 = rq[1]; we1 = rw[1]; addr1 = ra[1]; wdata1 = rd[1];
            mem_data_out = 9'($urandom);
            drv[t] = mem_data_out;
            if (t >= nxt && (rq[0] || rq[1])) begin
                p = (rq[0] && rq[1]) ? 1 - last : (rq[1] ? 1 : 0);
                last = p;
                g = t + 1;
                d = rw[p] ? g + 1 : g + 1 + RD_LAT;
                e_ctl[g]  = (p == 1 ? 6'b010000 : 6'b100000) | (rw[p] ? 6'b000001 : 6'b000010);
                e_ctl[d]  = (p == 1) ? 6'b000100 : 6'b001000;
                e_addr[g] = ra[p];
                e_wd[g]   = rd[p];
                e_wr[g]   = rw[p];
                e_wr[d]   = rw[p];
                nxt = d + 1;
                mg[p]++;
            end
        end
        chk("rnd_gnt0_count", cg[0], mg[0]);
        chk("rnd_gnt1_count", cg[1], mg[1]);
        chk("rnd_done0_count", cd[0], mg[0]);
        chk("rnd_done1_count", cd[1], mg[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
